// File: rtl/timing_core_pkg.sv
// timing_core_pkg
// Constants and types shared by the active-pixel loader and the
// active-pixel memory.
//   DEPTH          flags per map (one per pixel slot of a scan line)
//   ADDR_W         write address width, log2(DEPTH)
//   WORD_W         stream word width; DEPTH must be a multiple of it
//   loader_state_t loader FSM encoding
package timing_core_pkg;

    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 11;
    localparam int WORD_W = 32;
    localparam int CNT_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/active_pixel_loader_if.sv
// active_pixel_loader_if
// Valid/ready word stream carrying packed active-pixel flags.
//   data   packed flags, bit k lands at address base+k
//   valid  word valid (source -> loader)
//   ready  loader can take a word (loader -> source)
// Modports: master = stream source, slave = loader.
interface active_pixel_loader_if;
    import timing_core_pkg::*;

    logic [WORD_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/active_pixel_loader_bit_serializer.sv
// bit_serializer
// WORD_W-bit shift register plus bit counter. A load latches a word and
// then one bit per cycle is presented, LSB first, for WORD_W cycles.
//   clk_i, rst_i  clock, synchronous active-high reset
//   clear_i       drop the word in flight (flush)
//   load_i        latch data_i and start shifting next cycle
//   data_i        word to serialize
//   bit_o         current bit (registered)
//   busy_o        a bit is being presented this cycle (registered)
//   last_o        the presented bit is the final one of the word
module bit_serializer
    import timing_core_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              bit_o,
    output logic              busy_o,
    output logic              last_o
);

    logic [WORD_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            sreg   <= '0;
            cnt    <= '0;
            busy_o <= 1'b0;
        end else if (load_i) begin
            sreg   <= data_i;
            cnt    <= '0;
            busy_o <= 1'b1;
        end else if (busy_o) begin
            sreg <= sreg >> 1;
            cnt  <= cnt + 1'b1;
            if (last_o) busy_o <= 1'b0;
        end
    end

    assign bit_o  = sreg[0];
    assign last_o = busy_o && (cnt == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/active_pixel_loader.sv
// active_pixel_loader
// Fills the shadow bank of the ping-pong active-pixel memory from a word
// stream, one flag per cycle, and swaps banks on a timing-core boundary
// once the map is complete.
//   clk_i, rst_i    clock, synchronous active-high reset
//   s               word stream (slave side)
//   swap_i          boundary pulse; swaps banks only when a map is loaded
//   flush_i         abandon the partial map, restart at address 0
//   waddr_o/wdata_o/wen_o  memory write port
//   mem_selector_o  1: writes to bank 1, reads from bank 0
//   loaded_o        shadow bank complete, waiting for swap
//   swap_miss_o     one-cycle pulse: swap arrived before the map was complete
module active_pixel_loader
    import timing_core_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    active_pixel_loader_if.slave  s,
    input  logic                  swap_i,
    input  logic                  flush_i,
    output logic [ADDR_W-1:0]     waddr_o,
    output logic                  wdata_o,
    output logic                  wen_o,
    output logic                  mem_selector_o,
    output logic                  loaded_o,
    output logic                  swap_miss_o
);

    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0] state;
    logic       ready_q;
    logic       hs;
    logic       ser_last;
    logic       end_of_map;

    assign s.ready    = ready_q;
    // flush beats the stream: a word offered alongside flush is not taken
    assign hs         = s.valid && ready_q && !flush_i;
    assign end_of_map = (waddr_o == ADDR_W'(DEPTH - 1));

    bit_serializer u_ser (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(flush_i),
        .load_i (hs),
        .data_i (s.data),
        .bit_o  (wdata_o),
        .busy_o (wen_o),
        .last_o (ser_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_LOAD;
            ready_q        <= 1'b0;
            waddr_o        <= '0;
            mem_selector_o <= 1'b0;
            loaded_o       <= 1'b0;
            swap_miss_o    <= 1'b0;
        end else begin
            // any swap not landing in DONE is reported and otherwise ignored
            swap_miss_o <= swap_i && !flush_i && (state != ST_DONE);

            if (flush_i) begin
                state    <= ST_LOAD;
                waddr_o  <= '0;
                ready_q  <= 1'b1;
                loaded_o <= 1'b0;
            end else begin
                unique case (state)
                    ST_LOAD: begin
                        if (hs) begin
                            state   <= ST_SHIFT;
                            ready_q <= 1'b0;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (wen_o) begin
                            // pointer parks on DEPTH-1 rather than wrapping
                            if (ser_last && end_of_map) begin
                                state    <= ST_DONE;
                                loaded_o <= 1'b1;
                            end else begin
                                waddr_o <= waddr_o + 1'b1;
                                if (ser_last) begin
                                    state   <= ST_LOAD;
                                    ready_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        if (swap_i) begin
                            state          <= ST_LOAD;
                            mem_selector_o <= ~mem_selector_o;
                            waddr_o        <= '0;
                            loaded_o       <= 1'b0;
                            ready_q        <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_LOAD;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
